// File: rtl/bv4_mul_pipe.sv
// Elastic multi-lane GF(2^4) normal-basis multiplier with a per-lane accumulator.
// Modes: 00 MUL, 01 SQR (b := a), 10 MAC (acc ^= p), 11 LDM (acc := p).

module bv4_mul_lane #(
  parameter int PIPE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld1,
  input  logic       ldo,
  input  logic       sqr,
  input  logic [1:0] mode_o,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] c
);
  function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic logic [1:0] gf4_scl_n(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  logic [3:0] bo, p, res, acc;
  logic [1:0] d0_n, d1_n, d2_n, d0, d1, d2, mid;

  assign bo   = sqr ? a : b;
  assign d0_n = gf4_mul(a[1:0], bo[1:0]);
  assign d1_n = gf4_mul(a[3:2], bo[3:2]);
  assign d2_n = gf4_mul(a[1:0] ^ a[3:2], bo[1:0] ^ bo[3:2]);

  if (PIPE == 2) begin : g_s1
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)   {d0, d1, d2} <= '0;
      else if (ld1) {d0, d1, d2} <= {d0_n, d1_n, d2_n};
  end else begin : g_s0
    logic ld1_unused;
    assign ld1_unused   = ld1;
    assign {d0, d1, d2} = {d0_n, d1_n, d2_n};
  end

  assign mid = gf4_scl_n(d2);
  assign p   = {d1 ^ mid, d0 ^ mid};
  assign res = (mode_o == 2'b10) ? (p ^ acc) : p;

  // acc follows the output register, so it moves exactly once per result
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c   <= '0;
      acc <= '0;
    end else if (ldo) begin
      c <= res;
      if (mode_o[1]) acc <= res;
    end
endmodule

module bv4_mul_pipe #(
  parameter int LANES = 4,
  parameter int PIPE  = 2
) (
  input  logic               in_clock,
  input  logic               in_reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_mode,
  input  logic [4*LANES-1:0] in_a,
  input  logic [4*LANES-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*LANES-1:0] out_c
);
  localparam logic [1:0] MODE_SQR = 2'b01;

  logic [PIPE:1] vld_pipe;
  logic [1:0]    mode_o;
  logic          ld_o, vld_src, accept, ldo;

  // in_ready depends only on state and out_ready, never on in_valid
  assign ld_o      = !vld_pipe[PIPE] || out_ready;
  assign in_ready  = (PIPE == 2) ? (!vld_pipe[1] || ld_o) : ld_o;
  assign vld_src   = (PIPE == 2) ? vld_pipe[1] : in_valid;
  assign accept    = in_valid && in_ready;
  assign ldo       = ld_o && vld_src;
  assign out_valid = vld_pipe[PIPE];

  always_ff @(posedge in_clock or negedge in_reset_n)
    if (!in_reset_n) vld_pipe <= '0;
    else begin
      if (ld_o) vld_pipe[PIPE] <= vld_src;
      if (PIPE == 2 && in_ready) vld_pipe[1] <= in_valid;
    end

  if (PIPE == 2) begin : g_mode
    logic [1:0] mode_q;
    always_ff @(posedge in_clock or negedge in_reset_n)
      if (!in_reset_n)  mode_q <= '0;
      else if (accept) mode_q <= in_mode;
    assign mode_o = mode_q;
  end else begin : g_mode_comb
    assign mode_o = in_mode;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bv4_mul_lane #(.PIPE(PIPE)) u_lane (
      .clk    (in_clock),
      .rst_n  (in_reset_n),
      .ld1    (accept),
      .ldo    (ldo),
      .sqr    (in_mode == MODE_SQR),
      .mode_o (mode_o),
      .a      (in_a[4*i +: 4]),
      .b      (in_b[4*i +: 4]),
      .c      (out_c[4*i +: 4])
    );
  end
endmodule

// File: tb/tb_bv4_mul_pipe.sv
// Bench for bv4_mul_pipe: PIPE=1 and PIPE=2 instances share stimulus; a GF(16)
// log-table model plus per-instance result queues give every expected value.

module tb_bv4_mul_pipe;
  localparam logic [1:0] M_MUL = 2'd0, M_SQR = 2'd1, M_MAC = 2'd2, M_LDM = 2'd3;

  typedef struct { logic [15:0] c; int cyc; } exp_t;

  logic             in_clock = 1'b0, in_reset_n = 1'b0;
  logic             in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0]       in_mode = 2'd0;
  logic [15:0]      in_a = 16'h0, in_b = 16'h0;
  logic [1:0]       rdy, ov;
  logic [1:0][15:0] oc;

  int   n_cmp = 0, n_err = 0, cyc = 0;
  exp_t q0[$], q1[$];
  logic [3:0]  macc [2][4];
  logic [1:0]  held, acc_flag, got;
  logic [16:0] prev [2];
  logic [15:0] last_oc [2];
  bit          lat_chk;

  always #5 in_clock = ~in_clock;

  bv4_mul_pipe #(.LANES(4), .PIPE(1)) u_dut1 (
    .in_clock(in_clock), .in_reset_n(in_reset_n), .in_valid(in_valid), .in_ready(rdy[0]),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .out_valid(ov[0]), .out_ready(out_ready),
    .out_c(oc[0]));

  bv4_mul_pipe #(.LANES(4), .PIPE(2)) u_dut2 (
    .in_clock(in_clock), .in_reset_n(in_reset_n), .in_valid(in_valid), .in_ready(rdy[1]),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b), .out_valid(ov[1]), .out_ready(out_ready),
    .out_c(oc[1]));

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_cmp++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got_v, exp_v, cyc);
    end
  endtask

  // GF(4) as {0, W, W^2, 1}: 01=W, 10=W^2, 11=1; multiply by adding logs mod 3
  function automatic int lg4(input logic [1:0] x);
    return (x == 2'd1) ? 1 : (x == 2'd2) ? 2 : 0;
  endfunction

  function automatic logic [1:0] alg4(input int e);
    case (e % 3)
      0:       return 2'd3;
      1:       return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] gf4m(input logic [1:0] x, input logic [1:0] y);
    if (x == 2'd0 || y == 2'd0) return 2'd0;
    return alg4(lg4(x) + lg4(y));
  endfunction

  // N = W^2 = 2'b10
  function automatic logic [3:0] gf16m(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] d0, d1, mid;
    d0  = gf4m(x[1:0], y[1:0]);
    d1  = gf4m(x[3:2], y[3:2]);
    mid = gf4m(2'b10, gf4m(x[1:0] ^ x[3:2], y[1:0] ^ y[3:2]));
    return {d1 ^ mid, d0 ^ mid};
  endfunction

  function automatic logic [15:0] model_op(input int d, input logic [1:0] m,
                                           input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic [3:0]  la, lb, p;
    r = 16'h0;
    for (int i = 0; i < 4; i++) begin
      la = a[4*i +: 4];
      lb = (m == M_SQR) ? la : b[4*i +: 4];
      p  = gf16m(la, lb);
      if (m == M_MAC) p = p ^ macc[d][i];
      if (m == M_MAC || m == M_LDM) macc[d][i] = p;
      r[4*i +: 4] = p;
    end
    return r;
  endfunction

  task automatic observe();
    for (int d = 0; d < 2; d++) begin
      int   pend;
      exp_t e;
      pend = (d == 0) ? q0.size() : q1.size();
      if (held[d]) chk("stall_hold", 32'({ov[d], oc[d]}), 32'(prev[d]));
      chk("in_ready", 32'(rdy[d]), 32'(!(pend == d + 1 && !out_ready)));
      if (ov[d] && out_ready) begin
        got[d]     = 1'b1;
        last_oc[d] = oc[d];
        if (pend == 0) chk("spurious_out", 32'(ov[d]), 32'd0);
        else begin
          if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk((d == 0) ? "out_c_p1" : "out_c_p2", 32'(oc[d]), 32'(e.c));
          if (lat_chk) chk("latency", cyc - e.cyc, d + 1);
        end
      end
      acc_flag[d] = in_valid && rdy[d];
      if (acc_flag[d]) begin
        e.c   = model_op(d, in_mode, in_a, in_b);
        e.cyc = cyc;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
      held[d] = ov[d] && !out_ready;
      prev[d] = {ov[d], oc[d]};
    end
    cyc++;
  endtask

  task automatic step(input logic v, input logic [1:0] m, input logic [15:0] a,
                      input logic [15:0] b, input logic ordy);
    in_valid = v; in_mode = m; in_a = a; in_b = b; out_ready = ordy;
    #1 observe();
    @(negedge in_clock);
  endtask

  task automatic do_op(input logic [1:0] m, input logic [15:0] a, input logic [15:0] b,
                       output logic [15:0] r0, output logic [15:0] r1);
    got = 2'b00;
    step(1'b1, m, a, b, 1'b1);
    for (int k = 0; k < 6 && got != 2'b11; k++) step(1'b0, M_MUL, 16'h0, 16'h0, 1'b1);
    chk("op_done", 32'(got), 32'd3);
    r0 = last_oc[0];
    r1 = last_oc[1];
  endtask

  task automatic chk2(input string tag, input logic [15:0] r0, input logic [15:0] r1,
                      input logic [15:0] e);
    chk({tag, "_p1"}, 32'(r0), 32'(e));
    chk({tag, "_p2"}, 32'(r1), 32'(e));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] r0, r1, a, b, sq;
    logic [1:0]  m;
    logic        v, need;
    int          idx, ops, guard;

    held = 2'b00; got = 2'b00; acc_flag = 2'b00; lat_chk = 1'b1;
    a = 16'h0; b = 16'h0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) macc[d][i] = 4'h0;

    repeat (2) @(negedge in_clock);
    chk("rst_ov", 32'(ov), 32'd0);
    chk("rst_oc_p1", 32'(oc[0]), 32'd0);
    chk("rst_oc_p2", 32'(oc[1]), 32'd0);
    in_reset_n = 1'b1;
    @(negedge in_clock);

    // all 256 operand pairs, four per op, streamed back to back
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < 4; i++) begin
        idx = 4*k + i;
        a[4*i +: 4] = idx[7:4];
        b[4*i +: 4] = idx[3:0];
      end
      step(1'b1, M_MUL, a, b, 1'b1);
    end
    repeat (4) step(1'b0, M_MUL, 16'h0, 16'h0, 1'b1);

    do_op(M_MUL, 16'hFA73, 16'hFFFF, r0, r1); chk2("ident", r0, r1, 16'hFA73);
    do_op(M_MUL, 16'hFA73, 16'h0000, r0, r1); chk2("zero", r0, r1, 16'h0000);

    a = 16'hC965;
    for (int i = 0; i < 4; i++) sq[4*i +: 4] = gf16m(a[4*i +: 4], a[4*i +: 4]);
    for (int r = 0; r < 2; r++) begin
      do_op(M_SQR, a, 16'($urandom), r0, r1); chk2("sqr", r0, r1, sq);
    end

    do_op(M_LDM, 16'hFFFF, 16'h6666, r0, r1); chk2("ldm", r0, r1, 16'h6666);
    do_op(M_MAC, 16'hFFFF, 16'h3333, r0, r1); chk2("mac1", r0, r1, 16'h5555);
    do_op(M_MAC, 16'hFFFF, 16'h5555, r0, r1); chk2("mac2", r0, r1, 16'h0000);
    do_op(M_MUL, 16'hFFFF, 16'h7777, r0, r1); chk2("mul_mid", r0, r1, 16'h7777);
    do_op(M_MAC, 16'hFFFF, 16'h1111, r0, r1); chk2("mac3", r0, r1, 16'h1111);

    // random modes under 50% backpressure; stimulus held until PIPE=2 takes it
    lat_chk = 1'b0;
    ops = 0; guard = 0; need = 1'b1; v = 1'b0; m = M_MUL;
    while (ops < 1000 && guard < 20000) begin
      if (need) begin
        v = ($urandom_range(0, 9) < 7);
        m = 2'($urandom); a = 16'($urandom); b = 16'($urandom);
      end
      step(v, m, a, b, ($urandom_range(0, 1) == 1));
      guard++;
      if (acc_flag[1]) ops++;
      need = !v || acc_flag[1];
    end
    chk("bp_ops", ops, 1000);
    repeat (8) step(1'b0, M_MUL, 16'h0, 16'h0, 1'b1);
    chk("drain_p1", q0.size(), 0);
    chk("drain_p2", q1.size(), 0);

    // reset with work in flight and acc = 6 in every lane
    step(1'b1, M_LDM, 16'hFFFF, 16'h6666, 1'b0);
    step(1'b1, M_MAC, 16'hFFFF, 16'h3333, 1'b0);
    chk("pre_rst_ov", 32'(ov), 32'd3);
    in_valid = 1'b0;
    #2 in_reset_n = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(ov), 32'd0);
    chk("mid_rst_oc_p1", 32'(oc[0]), 32'd0);
    chk("mid_rst_oc_p2", 32'(oc[1]), 32'd0);
    q0.delete(); q1.delete(); held = 2'b00;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 4; i++) macc[d][i] = 4'h0;
    @(negedge in_clock);
    in_reset_n = 1'b1;
    lat_chk = 1'b1;
    repeat (3) step(1'b0, M_MUL, 16'h0, 16'h0, 1'b1);
    do_op(M_MAC, 16'hFFFF, 16'h3333, r0, r1); chk2("post_rst_mac", r0, r1, 16'h3333);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
